// File: rtl/brick_pkg.sv
// Shared constants for the BrickBreaker VGA datapath:
// screen geometry, colour palette and draw-engine state codes.
package brick_pkg;

    localparam int COORD_W = 10;
    localparam int SCR_W   = 160;
    localparam int SCR_H   = 120;

    localparam logic [2:0] C_BLACK   = 3'b000;
    localparam logic [2:0] C_BLUE    = 3'b001;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_CYAN    = 3'b011;
    localparam logic [2:0] C_RED     = 3'b100;
    localparam logic [2:0] C_MAGENTA = 3'b101;
    localparam logic [2:0] C_YELLOW  = 3'b110;
    localparam logic [2:0] C_WHITE   = 3'b111;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ERASE = 3'd1;
    localparam state_t S_MOVE  = 3'd2;
    localparam state_t S_DRAW  = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/rect_scanner.sv
// Row-major W x H pixel offset counter with clear, advance and last flag.
// Shared by the paddle, brick and ball erase/draw engines.
module rect_scanner #(
    parameter int W  = 20,
    parameter int H  = 2,
    parameter int XW = (W > 1) ? $clog2(W) : 1,
    parameter int YW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [XW-1:0] qx_o,
    output logic [YW-1:0] qy_o,
    output logic          last_o
);

    logic [XW-1:0] qx_q, qx_d;
    logic [YW-1:0] qy_q, qy_d;
    logic          x_end, y_end;

    assign x_end  = (qx_q == XW'(W - 1));
    assign y_end  = (qy_q == YW'(H - 1));
    assign last_o = x_end && y_end;
    assign qx_o   = qx_q;
    assign qy_o   = qy_q;

    always_comb begin
        qx_d = qx_q;
        qy_d = qy_q;
        if (clr_i) begin
            qx_d = '0;
            qy_d = '0;
        end else if (adv_i) begin
            if (x_end) begin
                qx_d = '0;
                qy_d = y_end ? '0 : qy_q + 1'b1;
            end else begin
                qx_d = qx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            qx_q <= '0;
            qy_q <= '0;
        end else begin
            qx_q <= qx_d;
            qy_q <= qy_d;
        end
    end

endmodule

// File: rtl/paddle_engine.sv
// Paddle mover/renderer: erases the old footprint, clamps and commits
// the new left edge, then redraws it through the VGA write port.
module paddle_engine #(
    parameter int         COORD_W   = 10,
    parameter int         PAD_W     = 20,
    parameter int         PAD_H     = 2,
    parameter int         SPEED     = 1,
    parameter int         X_MAX     = 159,
    parameter int         X_INIT    = 32,
    parameter int         Y_POS     = 64,
    parameter logic [2:0] FG_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               enable,
    input  logic               draw,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [2:0]         colour,
    output logic               writeEn,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] pad_x
);

    import brick_pkg::*;

    localparam int XW  = (PAD_W > 1) ? $clog2(PAD_W) : 1;
    localparam int YW  = (PAD_H > 1) ? $clog2(PAD_H) : 1;
    localparam int CW1 = COORD_W + 1;

    localparam logic [COORD_W:0] SPD = CW1'(SPEED);
    localparam logic [COORD_W:0] LIM = CW1'(X_MAX - PAD_W + 1);

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   pad_x_q, pad_x_d;
    logic [COORD_W-1:0]   tgt_q, tgt_d;
    logic                 drawn_q, drawn_d;

    logic [COORD_W:0]     dec, inc;
    logic [COORD_W-1:0]   left_x, right_x, new_x;
    logic                 go_l, go_r, scan, last;
    logic [XW-1:0]        qx;
    logic [YW-1:0]        qy;

    // One spare bit catches underflow on the left and overshoot on the right.
    assign dec     = {1'b0, pad_x_q} - SPD;
    assign inc     = {1'b0, pad_x_q} + SPD;
    assign left_x  = dec[COORD_W] ? '0 : dec[COORD_W-1:0];
    assign right_x = (inc > LIM) ? LIM[COORD_W-1:0] : inc[COORD_W-1:0];

    assign go_l  = enable && left && !right;
    assign go_r  = enable && right && !left;
    assign new_x = go_l ? left_x : (go_r ? right_x : pad_x_q);

    assign scan = (state_q == S_ERASE) || (state_q == S_DRAW);

    rect_scanner #(
        .W (PAD_W),
        .H (PAD_H),
        .XW(XW),
        .YW(YW)
    ) u_scan (
        .clk    (clk),
        .reset_i(reset),
        .clr_i  (!scan),
        .adv_i  (scan),
        .qx_o   (qx),
        .qy_o   (qy),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        pad_x_d = pad_x_q;
        tgt_d   = tgt_q;
        drawn_d = drawn_q;
        unique case (state_q)
            S_IDLE: begin
                if (draw) begin
                    tgt_d   = new_x;
                    state_d = (drawn_q && new_x != pad_x_q) ? S_ERASE : S_MOVE;
                end
            end
            S_ERASE: if (last) state_d = S_MOVE;
            S_MOVE: begin
                pad_x_d = tgt_q;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (last) begin
                    drawn_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pad_x_q <= COORD_W'(X_INIT);
            tgt_q   <= COORD_W'(X_INIT);
            drawn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pad_x_q <= pad_x_d;
            tgt_q   <= tgt_d;
            drawn_q <= drawn_d;
        end
    end

    assign x       = scan ? pad_x_q + COORD_W'(qx) : pad_x_q;
    assign y       = scan ? COORD_W'(Y_POS) + COORD_W'(qy) : COORD_W'(Y_POS);
    assign colour  = (state_q == S_ERASE) ? BG_COLOUR : FG_COLOUR;
    assign writeEn = scan;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign pad_x   = pad_x_q;

endmodule

// File: tb/tb_paddle_engine.sv
// Bench for paddle_engine: cycle model on the default instance plus
// directed latency/count checks on three parameterisations.
module tb_paddle_engine;

    localparam int W    = 20;
    localparam int H    = 2;
    localparam int SPD  = 1;
    localparam int XMAX = 159;
    localparam int XI   = 32;
    localparam int YP   = 64;
    localparam int FG   = 4;
    localparam int BG   = 0;

    typedef struct {
        int x;
        int y;
        int col;
        bit we;
        bit busy;
        bit done;
        int pad;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    logic left = 0, right = 0, enable = 0, draw = 0;
    logic draw_m, draw2, draw3;
    int   sel = 0;

    logic [9:0] x1, y1, pad1, x2, y2, pad2, x3, y3, pad3;
    logic [2:0] col1, col2, col3;
    logic       we1, we2, we3, busy1, busy2, busy3, done1, done2, done3;

    logic [2:0] s_col;
    logic [9:0] s_pad;
    logic       s_we, s_busy, s_done;

    int   total = 0;
    int   bad = 0;
    bit   chk_en = 0;
    int   cyc = 0;

    exp_t q[$];
    int   mpad;
    bit   mdrawn;

    always #5 clk = ~clk;

    assign draw_m = draw && (sel == 0);
    assign draw2  = draw && (sel == 1);
    assign draw3  = draw && (sel == 2);

    paddle_engine dut (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .enable(enable), .draw(draw_m), .x(x1), .y(y1), .colour(col1),
        .writeEn(we1), .busy(busy1), .done(done1), .pad_x(pad1)
    );

    paddle_engine #(.SPEED(4), .X_INIT(138)) dut2 (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .enable(enable), .draw(draw2), .x(x2), .y(y2), .colour(col2),
        .writeEn(we2), .busy(busy2), .done(done2), .pad_x(pad2)
    );

    paddle_engine #(.PAD_W(1), .PAD_H(1)) dut3 (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .enable(enable), .draw(draw3), .x(x3), .y(y3), .colour(col3),
        .writeEn(we3), .busy(busy3), .done(done3), .pad_x(pad3)
    );

    always_comb begin
        s_we = we1; s_busy = busy1; s_done = done1;
        s_col = col1; s_pad = pad1;
        if (sel == 1) begin
            s_we = we2; s_busy = busy2; s_done = done2;
            s_col = col2; s_pad = pad2;
        end else if (sel == 2) begin
            s_we = we3; s_busy = busy3; s_done = done3;
            s_col = col3; s_pad = pad3;
        end
    end

    // Model: on accept, enqueue the whole expected per-cycle output stream.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            q.delete();
            mpad   = XI;
            mdrawn = 0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (draw_m) begin
            int np;
            bit er;
            if (enable && left && !right)
                np = (mpad - SPD < 0) ? 0 : mpad - SPD;
            else if (enable && right && !left)
                np = (mpad + SPD > XMAX - W + 1) ? XMAX - W + 1 : mpad + SPD;
            else
                np = mpad;
            er = mdrawn && (np != mpad);
            if (er)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        q.push_back('{mpad + c, YP + r, BG, 1, 1, 0, mpad});
            q.push_back('{mpad, YP, FG, 0, 1, 0, mpad});
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    q.push_back('{np + c, YP + r, FG, 1, 1, 0, np});
            q.push_back('{np, YP, FG, 0, 1, 1, np});
            mpad   = np;
            mdrawn = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            if (q.size() > 0) e = q[0];
            else e = '{mpad, YP, FG, 0, 0, 0, mpad};
            total++;
            if (int'(x1) != e.x || int'(y1) != e.y || int'(col1) != e.col ||
                we1 != e.we || busy1 != e.busy || done1 != e.done ||
                int'(pad1) != e.pad) begin
                bad++;
                $display("FAIL model cyc%0d: x=%0d/%0d y=%0d/%0d col=%0d/%0d we=%0d/%0d busy=%0d/%0d done=%0d/%0d pad=%0d/%0d (got/expected)",
                    cyc, x1, e.x, y1, e.y, col1, e.col, we1, e.we,
                    busy1, e.busy, done1, e.done, pad1, e.pad);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_draw(input logic l, input logic r, input logic en,
                            input int e_lat, input int e_wr, input int e_bg,
                            input int e_pad, input int e_fw, input string nm);
        int lat, wr, bg, nb, fw;
        bit seen;
        @(posedge clk); #1;
        left = l; right = r; enable = en; draw = 1;
        @(posedge clk); #1;
        draw = 0;
        lat = 0; wr = 0; bg = 0; nb = 0; fw = -1; seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            lat++;
            @(negedge clk);
            if (s_we) begin
                wr++;
                if (fw < 0) fw = lat;
                if (s_col == 3'(BG)) bg++;
            end
            if (!s_busy) nb++;
            if (s_done) seen = 1;
        end
        chk({nm, " done seen"}, int'(seen), 1);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " writes"}, wr, e_wr);
        chk({nm, " erase writes"}, bg, e_bg);
        chk({nm, " busy low"}, nb, 0);
        chk({nm, " pad_x"}, int'(s_pad), e_pad);
        if (e_fw >= 0) chk({nm, " first write"}, fw, e_fw);
        @(negedge clk);
        chk({nm, " idle busy"}, int'(s_busy), 0);
    endtask

    initial begin
        int ndone;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset we", int'(we1), 0);
        chk("reset busy", int'(busy1), 0);
        chk("reset done", int'(done1), 0);
        chk("reset x", int'(x1), 32);
        chk("reset y", int'(y1), 64);
        chk("reset colour", int'(col1), 4);
        chk("reset pad", int'(pad1), 32);

        run_draw(0, 0, 0, 42, 40, 0, 32, 2, "first");
        run_draw(0, 1, 1, 82, 80, 40, 33, 1, "right");

        // draw pulse during DRAW must be dropped
        @(posedge clk); #1;
        left = 0; right = 1; enable = 1; draw = 1;
        @(posedge clk); #1;
        draw = 0;
        ndone = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (done1) ndone++;
            draw = (i == 50);
        end
        draw = 0;
        chk("pulse dones", ndone, 1);
        chk("pulse pad", int'(pad1), 34);

        // reset in the middle of the erase scan
        @(posedge clk); #1;
        right = 1; enable = 1; draw = 1;
        @(posedge clk); #1;
        draw = 0;
        repeat (9) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("midreset we", int'(we1), 0);
        chk("midreset busy", int'(busy1), 0);
        chk("midreset pad", int'(pad1), 32);
        run_draw(0, 1, 1, 42, 40, 0, 33, 2, "post reset");

        for (int p = 33; p >= 1; p--)
            run_draw(1, 0, 1, 82, 80, 40, p - 1, 1, "walk left");
        run_draw(1, 0, 1, 42, 40, 0, 0, 2, "left at 0");
        run_draw(1, 1, 1, 42, 40, 0, 0, -1, "both dirs");
        run_draw(0, 1, 0, 42, 40, 0, 0, -1, "disabled");

        sel = 1;
        run_draw(0, 1, 1, 42, 40, 0, 140, -1, "speed4 clamp");
        run_draw(0, 1, 1, 42, 40, 0, 140, -1, "speed4 at edge");

        sel = 2;
        run_draw(0, 0, 0, 3, 1, 0, 32, 2, "1x1 first");
        run_draw(0, 1, 1, 4, 2, 1, 33, 1, "1x1 erase");
        sel = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
